// File: rtl/pam_symbol_sampler_if.sv
// Bundles the sampler's data-path signals.
//   master: drives the raw sample, the estimator outputs (period, phase_time,
//           phase_mark) and the slicer thresholds; receives the symbol stream.
//   slave : the sampler itself.
// Outputs returned to the master: sym, sym_valid, sample_out, locked, sym_count.
interface pam_symbol_sampler_if #(
  parameter int DATA_W   = 14,
  parameter int PERIOD_W = 21,
  parameter int PHASE_W  = 10
);
  logic signed [DATA_W-1:0]   signal_in;
  logic        [PERIOD_W-1:0] period;
  logic        [PHASE_W-1:0]  phase_time;
  logic                       phase_mark;
  logic signed [DATA_W-1:0]   thr_lo;
  logic signed [DATA_W-1:0]   thr_mid;
  logic signed [DATA_W-1:0]   thr_hi;
  logic        [1:0]          sym;
  logic                       sym_valid;
  logic signed [DATA_W-1:0]   sample_out;
  logic                       locked;
  logic        [15:0]         sym_count;

  modport master (
    output signal_in, period, phase_time, phase_mark, thr_lo, thr_mid, thr_hi,
    input  sym, sym_valid, sample_out, locked, sym_count
  );

  modport slave (
    input  signal_in, period, phase_time, phase_mark, thr_lo, thr_mid, thr_hi,
    output sym, sym_valid, sample_out, locked, sym_count
  );
endinterface

// File: rtl/pam_symbol_sampler.sv
// Samples a PAM stream once per symbol at the centre predicted by the
// period/phase estimator, slices it into one of four levels and tracks
// period stability to report lock.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - pam_symbol_sampler_if.slave:
//          in : signal_in, period, phase_time, phase_mark, thr_lo/mid/hi
//          out: sym, sym_valid (1-cycle pulse), sample_out, locked, sym_count
module pam_symbol_sampler #(
  parameter int DATA_W   = 14,
  parameter int PERIOD_W = 21,
  parameter int PHASE_W  = 10,
  parameter int LOCK_CNT = 8,
  parameter int TOL      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pam_symbol_sampler_if.slave   bus
);

  localparam int LCW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, ALIGN, TRACK} state_t;

  state_t                     state;
  logic        [PERIOD_W-1:0] cnt;
  logic        [PERIOD_W-1:0] period_r;
  logic        [PHASE_W-1:0]  offset_r;
  logic        [LCW-1:0]      lock_cnt;
  logic        [LCW-1:0]      lock_nxt;
  logic                       locked_r;
  logic        [15:0]         sym_count_r;

  logic                       dec_p0;
  logic                       period_ok_p0;
  logic        [PERIOD_W:0]   diff_p0;
  logic        [PERIOD_W:0]   dist_p0;
  logic                       stable_p0;

  logic                       vld_p1;
  logic        [1:0]          sym_p1;
  logic signed [DATA_W-1:0]   sample_p1;

  // Four-level slicer; compares run in priority order so unordered
  // thresholds still yield a deterministic symbol.
  function automatic logic [1:0] slice(input logic signed [DATA_W-1:0] x,
                                       input logic signed [DATA_W-1:0] lo,
                                       input logic signed [DATA_W-1:0] mid,
                                       input logic signed [DATA_W-1:0] hi);
    if (x >= hi)       return 2'd3;
    else if (x >= mid) return 2'd2;
    else if (x >= lo)  return 2'd1;
    else               return 2'd0;
  endfunction

  // ---- stage p0: decision instant and lock bookkeeping ----
  always_comb begin
    dec_p0       = ((state == ALIGN) && (cnt == PERIOD_W'(offset_r))) ||
                   ((state == TRACK) && (cnt == period_r - PERIOD_W'(1)));
    period_ok_p0 = (bus.period >= PERIOD_W'(2));
    // One extra bit keeps the difference signed so the magnitude is exact.
    diff_p0      = {1'b0, bus.period} - {1'b0, period_r};
    dist_p0      = diff_p0[PERIOD_W] ? (~diff_p0 + (PERIOD_W+1)'(1)) : diff_p0;
    stable_p0    = (dist_p0 <= (PERIOD_W+1)'(TOL));

    lock_nxt = lock_cnt;
    if (bus.phase_mark && (state != IDLE)) begin
      if (period_ok_p0 && stable_p0)
        lock_nxt = (lock_cnt == LCW'(LOCK_CNT)) ? lock_cnt : lock_cnt + LCW'(1);
      else
        lock_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      period_r    <= '0;
      offset_r    <= '0;
      lock_cnt    <= '0;
      locked_r    <= 1'b0;
      sym_count_r <= '0;
      vld_p1      <= 1'b0;
      sym_p1      <= '0;
      sample_p1   <= '0;
    end else begin
      // ---- stage p1: registered decision outputs ----
      vld_p1 <= dec_p0;
      if (dec_p0) begin
        sample_p1   <= bus.signal_in;
        sym_p1      <= slice(bus.signal_in, bus.thr_lo, bus.thr_mid, bus.thr_hi);
        sym_count_r <= sym_count_r + 16'd1;
      end

      lock_cnt <= lock_nxt;
      locked_r <= (lock_nxt == LCW'(LOCK_CNT));

      case (state)
        IDLE: begin
          if (bus.phase_mark && period_ok_p0) begin
            period_r <= bus.period;
            offset_r <= bus.phase_time;
            cnt      <= '0;
            state    <= ALIGN;
          end
        end
        ALIGN, TRACK: begin
          cnt <= cnt + PERIOD_W'(1);
          if (dec_p0) begin
            cnt   <= '0;
            state <= TRACK;
          end
          // A mark overrides the decision's counter restart; the sample
          // taken this cycle is still emitted above.
          if (bus.phase_mark) begin
            cnt <= '0;
            if (period_ok_p0) begin
              period_r <= bus.period;
              offset_r <= bus.phase_time;
              state    <= ALIGN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sym        = sym_p1;
  assign bus.sym_valid  = vld_p1;
  assign bus.sample_out = sample_p1;
  assign bus.locked     = locked_r;
  assign bus.sym_count  = sym_count_r;

endmodule

// File: doc/pam_symbol_sampler.md
Name: pam_symbol_sampler

Overview:
- Downstream of the moving-average period/phase estimator.
- Consumes the raw 14-bit PAM signal plus the estimator's period, phase_time and phase_mark outputs.
- Samples the signal once per symbol at the estimated centre and slices it into a 4-level PAM symbol.
- Tracks period stability and reports lock; output feeds the symbol/bit unpacking stage.

Parameters:
DATA_W, 14, signal sample width (two's complement)
PERIOD_W, 21, width of period input
PHASE_W, 10, width of phase_time input
LOCK_CNT, 8, consecutive stable phase_marks required to assert locked
TOL, 4, max |period change| between marks still counted as stable

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
signal_in  in  DATA_W  signed PAM sample, one per clk
period  in  PERIOD_W  estimated symbol period in clk cycles
phase_time  in  PHASE_W  offset from phase_mark to symbol centre, in cycles
phase_mark  in  1  one-cycle strobe; period/phase_time valid in the same cycle
thr_lo  in  DATA_W  signed lower slicer threshold
thr_mid  in  DATA_W  signed middle slicer threshold
thr_hi  in  DATA_W  signed upper slicer threshold
sym  out  2  sliced symbol (0..3)
sym_valid  out  1  one-cycle pulse, sym/sample_out valid
sample_out  out  DATA_W  raw sample taken at the decision instant
locked  out  1  period stable for LOCK_CNT marks
sym_count  out  16  symbols emitted since reset, wraps at 65535->0

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, period_r=0, offset_r=0, lock_cnt=0; outputs sym=0, sym_valid=0, sample_out=0, locked=0, sym_count=0.
- State machine states: IDLE, ALIGN, TRACK.
- IDLE:
  - On phase_mark with period>=2: latch period_r=period and offset_r=phase_time; cnt=0; go to ALIGN.
  - On phase_mark with period<2: ignore and stay in IDLE.
- ALIGN:
  - cnt increments each cycle.
  - Decision instant when cnt==offset_r; then go to TRACK with cnt=0.
  - With phase_time=0, the decision is on the first cycle after the mark.
- TRACK:
  - cnt increments each cycle.
  - Decision instant when cnt==period_r-1; then cnt=0.
- phase_mark in ALIGN or TRACK:
  - period>=2: relatch period_r/offset_r, cnt=0, go to ALIGN (realign).
  - period<2: go to IDLE and clear lock_cnt.
- phase_mark coincident with a decision instant: the sample is still taken and emitted; realignment applies from the next cycle.
- Decision instant:
  - signal_in is registered into sample_out.
  - Slicing, with signed compares evaluated in priority order:
    - signal_in>=thr_hi -> sym=3
    - else >=thr_mid -> sym=2
    - else >=thr_lo -> sym=1
    - else sym=0
  - sym_valid pulses exactly 1 cycle after the decision cycle (latency 1); sym_count increments in the same cycle.
- sym/sample_out hold their last value between pulses.
- Lock tracking:
  - On every phase_mark taken in ALIGN/TRACK, compute d=|period - period_r(old)| at PERIOD_W+1 bits.
  - d<=TOL: lock_cnt increments, saturating at LOCK_CNT.
  - d>TOL: lock_cnt=0.
  - locked = (lock_cnt==LOCK_CNT), registered; it drops the cycle after a failing mark.
  - The first mark from IDLE does not count.
- Thresholds are not checked for ordering. If unordered, the priority order still defines the result.
- cnt is PERIOD_W bits. period_r-1 never underflows because period_r>=2 is guaranteed.
- rst asserted mid-operation: immediate return to reset values. No sym_valid is emitted for a pending decision.

Test Plan:
- Period 1: thr=-4000/0/4000; mark with period=100, phase_time=50; signal constant 5000 -> first sym_valid 52 cycles after mark with sym=3, sample_out=5000; then sym_valid every 100 cycles.
- Period 2: signal stepping through -6000, -2000, 2000, 6000 per symbol -> sym 0, 1, 2, 3; sym_count=4.
- Period 3: 8 marks with period alternating 100/103 -> locked=1 after 8th counted mark; then mark with period=110 -> locked=0 the next cycle, and realign to the new period.
- Period 4: phase_time=0 -> decision on the cycle after the mark; mark with period=1 -> FSM to IDLE, no sym_valid, locked=0.
- Period 5: mark coincident with a TRACK decision cycle -> that sym_valid still emitted; next decision at offset_r+1 cycles after the mark.
- Period 6: rst asserted between decisions -> all outputs 0 immediately; sym_count=0; no pulses until a new mark; sym_count wrap verified by forcing 65535 -> 0.
